p_input_arb_strait: RTL and testbench

- Registered, handshaked successor to the single-select partial-sum input mux used in the STRAIT PE array.
- Arbitrates between a top-neighbour stream and a left-neighbour stream, each with valid/ready, under one of four runtime modes: fixed-left, fixed-top, round-robin or burst.
- Drives one registered output stream into the PE accumulator.
- Tags each output word with its source and counts delivered words for BIST observation.

---
 rtl/p_input_arb_strait.sv | 123 ++++++++++++
 tb/tb_p_input_arb_strait.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/p_input_arb_strait.sv
// Registered two-input stream arbiter feeding the STRAIT PE accumulator.
// Modes: fixed-left, fixed-top, round-robin, burst; tags source and counts delivered words.
module p_input_arb_strait #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  burst_len,
    input  logic              top_valid,
    input  logic [DATA_W-1:0] top_data,
    output logic              top_ready,
    input  logic              left_valid,
    input  logic [DATA_W-1:0] left_data,
    output logic              left_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  word_cnt
);

    typedef enum logic [1:0] {
        M_LEFT  = 2'b00,
        M_TOP   = 2'b01,
        M_RR    = 2'b10,
        M_BURST = 2'b11
    } mode_t;

    typedef enum logic {
        B_LEFT = 1'b0,
        B_TOP  = 1'b1
    } burst_t;

    mode_t            mode_q;
    logic             rr_last_top;
    burst_t           bstate;
    logic [CNT_W-1:0] bcnt;

    logic             ld;
    logic             grant_top;
    logic             accept;
    logic [CNT_W-1:0] blen_eff;
    logic [CNT_W:0]   bcnt_inc;
    logic             burst_done;

    assign ld = !out_valid || out_ready;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        grant_top = 1'b0;
        case (mode_q)
            M_LEFT:  grant_top = 1'b0;
            M_TOP:   grant_top = 1'b1;
            M_RR: begin
                if (top_valid && left_valid) grant_top = !rr_last_top;
                else                         grant_top = top_valid;
            end
            M_BURST: grant_top = (bstate == B_TOP);
            default: grant_top = 1'b0;
        endcase
    end

    // Readies are held low during the reset cycle so no word is consumed and lost.
    assign top_ready  = !rst && ld && grant_top  && top_valid;
    assign left_ready = !rst && ld && !grant_top && left_valid;
    assign accept     = top_ready || left_ready;

    assign blen_eff   = (burst_len == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : burst_len;
    assign bcnt_inc   = {1'b0, bcnt} + {{CNT_W{1'b0}}, 1'b1};
    assign burst_done = bcnt_inc >= {1'b0, blen_eff};

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
        end else if (ld) begin
            out_valid <= accept;
            if (accept) begin
                out_data <= top_ready ? top_data : left_data;
                out_src  <= top_ready;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt <= '0;
        end else if (out_valid && out_ready) begin
            word_cnt <= word_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= M_LEFT;
            rr_last_top <= 1'b1;
            bstate      <= B_LEFT;
            bcnt        <= '0;
        end else begin
            mode_q <= mode_t'(mode);
            if (accept && mode_q == M_RR) begin
                rr_last_top <= top_ready;
            end
            // A mode change restarts the burst sequence; the round-robin pointer is kept.
            if (mode_t'(mode) != mode_q) begin
                bstate <= B_LEFT;
                bcnt   <= '0;
            end else if (accept && mode_q == M_BURST) begin
                if (burst_done) begin
                    bcnt   <= '0;
                    bstate <= (bstate == B_LEFT) ? B_TOP : B_LEFT;
                end else begin
                    bcnt <= bcnt_inc[CNT_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_p_input_arb_strait.sv
// Randomised and phase-directed bench for p_input_arb_strait against a behavioural model.
module tb_p_input_arb_strait;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        mode = 2'b00;
    logic [CNT_W-1:0]  burst_len = '0;
    logic              top_valid = 1'b0;
    logic [DATA_W-1:0] top_data;
    logic              top_ready;
    logic              left_valid = 1'b0;
    logic [DATA_W-1:0] left_data;
    logic              left_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_src;
    logic              out_ready = 1'b1;
    logic [CNT_W-1:0]  word_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Per-source word sequence numbers; a source moves to its next word only once accepted.
    int unsigned top_seq  = 0;
    int unsigned left_seq = 0;
    assign top_data  = 32'h7000_0000 | top_seq;
    assign left_data = 32'hA000_0000 | left_seq;

    // Behavioural model state.
    bit          m_valid;
    bit [31:0]   m_data;
    bit          m_src;
    int          m_cnt;
    int          m_mode;
    bit          m_last_top;
    bit          m_burst_top;
    int          m_run;
    bit          e_top_ready;
    bit          e_left_ready;

    p_input_arb_strait #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .mode(mode), .burst_len(burst_len),
        .top_valid(top_valid), .top_data(top_data), .top_ready(top_ready),
        .left_valid(left_valid), .left_data(left_data), .left_ready(left_ready),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ready(out_ready), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Which source the rules pick this cycle, and whether it gets a ready.
    task automatic model_readies();
        bit room, want_top;
        room = !m_valid || out_ready;
        case (m_mode)
            0: want_top = 1'b0;
            1: want_top = 1'b1;
            2: want_top = (top_valid && left_valid) ? !m_last_top : top_valid;
            default: want_top = m_burst_top;
        endcase
        e_top_ready  = !rst && room && want_top && top_valid;
        e_left_ready = !rst && room && !want_top && left_valid;
    endtask

    task automatic model_update();
        int limit;
        if (rst) begin
            m_valid = 0; m_data = 0; m_src = 0; m_cnt = 0;
            m_mode = 0; m_last_top = 1; m_burst_top = 0; m_run = 0;
            return;
        end
        if (m_valid && out_ready) m_cnt = (m_cnt + 1) % 256;
        if (!m_valid || out_ready) begin
            m_valid = e_top_ready || e_left_ready;
            if (e_top_ready)  begin m_data = top_data;  m_src = 1; end
            if (e_left_ready) begin m_data = left_data; m_src = 0; end
        end
        if (m_mode == 2 && (e_top_ready || e_left_ready)) m_last_top = e_top_ready;
        limit = (burst_len == 0) ? 1 : int'(burst_len);
        if (int'(mode) != m_mode) begin
            m_burst_top = 0;
            m_run = 0;
        end else if (m_mode == 3 && (e_top_ready || e_left_ready)) begin
            m_run++;
            if (m_run >= limit) begin
                m_run = 0;
                m_burst_top = !m_burst_top;
            end
        end
        m_mode = int'(mode);
    endtask

    // One clock: drive at negedge, check readies, then check registers after the edge.
    task automatic step();
        bit took_top, took_left;
        @(negedge clk);
        #1;
        model_readies();
        check("top_ready", top_ready, e_top_ready);
        check("left_ready", left_ready, e_left_ready);
        took_top  = e_top_ready;
        took_left = e_left_ready;
        @(posedge clk);
        #1;
        model_update();
        if (took_top)  top_seq++;
        if (took_left) left_seq++;
        check("out_valid", out_valid, m_valid);
        check("out_src", out_src, m_src);
        check("word_cnt", word_cnt, m_cnt);
        if (m_valid || rst) check("out_data", out_data, m_data);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // Reset state.
        rst = 1; run(2);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_word_cnt", word_cnt, 0);
        rst = 0;

        // Fixed modes: left then top, both always valid.
        mode = 2'b00; top_valid = 1; left_valid = 1; out_ready = 1;
        run(3);
        mode = 2'b01; run(6);

        // Round-robin from reset, then a two-cycle top gap.
        rst = 1; run(1); rst = 0;
        mode = 2'b10; run(6);
        top_valid = 0; run(2);
        top_valid = 1; run(6);

        // Burst of 3, then burst_len 0 behaves as 1.
        mode = 2'b11; burst_len = 3; run(14);
        burst_len = 0; run(8);

        // Backpressure with a word held.
        burst_len = 2; run(2);
        out_ready = 0; run(4);
        out_ready = 1; run(3);

        // Reset mid-burst while a word is in the register.
        burst_len = 3; run(4);
        rst = 1; run(1); rst = 0;
        run(6);

        // Counter wrap: 257 delivered words from reset.
        rst = 1; run(1); rst = 0;
        mode = 2'b10; run(258);
        check("wrap_word_cnt", word_cnt, 8'd1);

        // Random phase.
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0)  burst_len = 8'($urandom_range(0, 4));
            top_valid  = ($urandom_range(0, 3) != 0);
            left_valid = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end

endmodule
